// File: rtl/exec_stage_pkg.sv
// Shared definitions for the execute stage: exec op codes and stage states.
// The decoder drives _op from the same op list.
package exec_stage_pkg;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_SLL    = 5'd2,
    OP_SLT    = 5'd3,
    OP_SLTU   = 5'd4,
    OP_XOR    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_OR     = 5'd8,
    OP_AND    = 5'd9,
    OP_LUI    = 5'd10,
    OP_AUIPC  = 5'd11,
    OP_JAL    = 5'd12,
    OP_JALR   = 5'd13,
    OP_BEQ    = 5'd14,
    OP_BNE    = 5'd15,
    OP_BLT    = 5'd16,
    OP_BGE    = 5'd17,
    OP_BLTU   = 5'd18,
    OP_BGEU   = 5'd19,
    OP_MUL    = 5'd20,
    OP_MULH   = 5'd21,
    OP_MULHSU = 5'd22,
    OP_MULHU  = 5'd23
  } op_e;

  typedef enum logic [0:0] {
    S_IDLE     = 1'b0,
    S_MUL_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/exec_stage_mul_iter.sv
// Iterative shift-add multiplier on operand magnitudes; one step per cycle,
// sign fix-up folded into the final step. Flush discards work in flight.
module mul_iter #(
  parameter int W      = 32,
  parameter int CYCLES = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           a_signed,
  input  logic           b_signed,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int CNT_W = $clog2(CYCLES);

  logic             busy;
  logic [CNT_W-1:0] cnt;
  logic [2*W-1:0]   mcand;
  logic [W-1:0]     mplier;
  logic [2*W-1:0]   acc;
  logic             neg;
  logic [2*W-1:0]   partial;
  logic [W-1:0]     mag_a;
  logic [W-1:0]     mag_b;

  assign mag_a   = (a_signed && a[W-1]) ? -a : a;
  assign mag_b   = (b_signed && b[W-1]) ? -b : b;
  assign partial = acc + (mplier[0] ? mcand : '0);
  assign done    = busy && (cnt == CNT_W'(CYCLES - 1));
  // Product is only sampled on the done edge, when partial holds the full sum.
  assign product = neg ? -partial : partial;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would chain the updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      neg    <= 1'b0;
    end else if (flush) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      mcand  <= {{W{1'b0}}, mag_a};
      mplier <= mag_b;
      acc    <= '0;
      neg    <= (a_signed && a[W-1]) ^ (b_signed && b[W-1]);
    end else if (busy) begin
      acc    <= partial;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= done ? '0 : cnt + CNT_W'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/exec_stage.sv
// Execute stage: single-cycle ALU/branch/jump ops, iterative RV32M multiply,
// single-entry output register to writeback and a one-cycle fetch redirect.
module exec_stage
  import exec_stage_pkg::*;
#(
  parameter int WORDSZ     = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic              _clk,
  input  logic              _reset,
  input  logic              _in_valid,
  output logic              in_ready_,
  input  logic [4:0]        _op,
  input  logic [WORDSZ-1:0] _src1,
  input  logic [WORDSZ-1:0] _src2,
  input  logic [WORDSZ-1:0] _imm,
  input  logic              _use_imm,
  input  logic [WORDSZ-1:0] _pc,
  input  logic [4:0]        _rd,
  input  logic              _flush,
  input  logic              _en_trace,
  input  logic              _out_ready,
  output logic              out_valid_,
  output logic [WORDSZ-1:0] out_result_,
  output logic [4:0]        out_rd_,
  output logic [WORDSZ-1:0] out_pc_,
  output logic              redirect_valid_,
  output logic [WORDSZ-1:0] redirect_pc_
);

  state_e              state;
  logic                accept;
  logic [WORDSZ-1:0]   opb;
  logic [4:0]          shamt;
  logic [WORDSZ-1:0]   alu_res;
  logic [WORDSZ-1:0]   target;
  logic [WORDSZ-1:0]   jalr_sum;
  logic                redir;
  logic                is_branch;
  logic                is_mul;
  logic                mul_hi;
  logic [4:0]          mul_rd;
  logic [WORDSZ-1:0]   mul_pc;
  logic                mul_done;
  logic [2*WORDSZ-1:0] mul_prod;
  logic                unused_trace;

  // Trace printing lives in simulation-only wrappers; the stage ignores it.
  assign unused_trace = _en_trace;

  assign in_ready_ = (state == S_IDLE) && !_flush && (!out_valid_ || _out_ready);
  assign accept    = _in_valid && in_ready_;
  assign opb       = _use_imm ? _imm : _src2;
  assign shamt     = opb[4:0];
  assign jalr_sum  = _src1 + _imm;
  assign is_mul    = _op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
  assign is_branch = _op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    alu_res = _src1 + opb;
    redir   = 1'b0;
    target  = _pc + _imm;
    case (_op)
      OP_SUB:   alu_res = _src1 - opb;
      OP_SLL:   alu_res = _src1 << shamt;
      OP_SLT:   alu_res = {{(WORDSZ-1){1'b0}}, $signed(_src1) < $signed(opb)};
      OP_SLTU:  alu_res = {{(WORDSZ-1){1'b0}}, _src1 < opb};
      OP_XOR:   alu_res = _src1 ^ opb;
      OP_SRL:   alu_res = _src1 >> shamt;
      OP_SRA:   alu_res = $signed(_src1) >>> shamt;
      OP_OR:    alu_res = _src1 | opb;
      OP_AND:   alu_res = _src1 & opb;
      OP_LUI:   alu_res = _imm;
      OP_AUIPC: alu_res = _pc + _imm;
      OP_JAL: begin
        alu_res = _pc + WORDSZ'(4);
        redir   = 1'b1;
      end
      OP_JALR: begin
        alu_res = _pc + WORDSZ'(4);
        redir   = 1'b1;
        target  = {jalr_sum[WORDSZ-1:1], 1'b0};
      end
      OP_BEQ:  begin alu_res = '0; redir = (_src1 == _src2); end
      OP_BNE:  begin alu_res = '0; redir = (_src1 != _src2); end
      OP_BLT:  begin alu_res = '0; redir = ($signed(_src1) <  $signed(_src2)); end
      OP_BGE:  begin alu_res = '0; redir = ($signed(_src1) >= $signed(_src2)); end
      OP_BLTU: begin alu_res = '0; redir = (_src1 <  _src2); end
      OP_BGEU: begin alu_res = '0; redir = (_src1 >= _src2); end
      default: ;
    endcase
  end

  mul_iter #(
    .W      (WORDSZ),
    .CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk      (_clk),
    .rst_n    (_reset),
    .flush    (_flush),
    .start    (accept && is_mul),
    .a        (_src1),
    .b        (_src2),
    .a_signed (_op == OP_MULH || _op == OP_MULHSU),
    .b_signed (_op == OP_MULH),
    .done     (mul_done),
    .product  (mul_prod)
  );

  always_ff @(posedge _clk or negedge _reset) begin
    if (!_reset) begin
      state           <= S_IDLE;
      out_valid_      <= 1'b0;
      out_result_     <= '0;
      out_rd_         <= '0;
      out_pc_         <= '0;
      redirect_valid_ <= 1'b0;
      redirect_pc_    <= '0;
      mul_hi          <= 1'b0;
      mul_rd          <= '0;
      mul_pc          <= '0;
    end else if (_flush) begin
      state           <= S_IDLE;
      out_valid_      <= 1'b0;
      redirect_valid_ <= 1'b0;
    end else begin
      redirect_valid_ <= 1'b0;
      if (accept && is_mul) begin
        state      <= S_MUL_BUSY;
        mul_hi     <= (_op != OP_MUL);
        mul_rd     <= _rd;
        mul_pc     <= _pc;
        out_valid_ <= 1'b0;
      end else if (accept) begin
        out_valid_      <= 1'b1;
        out_result_     <= alu_res;
        out_rd_         <= is_branch ? 5'd0 : _rd;
        out_pc_         <= _pc;
        redirect_valid_ <= redir;
        if (redir) redirect_pc_ <= target;
      end else if (state == S_MUL_BUSY && mul_done) begin
        // Acceptance required an empty/draining output, so the slot is free.
        state       <= S_IDLE;
        out_valid_  <= 1'b1;
        out_result_ <= mul_hi ? mul_prod[2*WORDSZ-1:WORDSZ] : mul_prod[WORDSZ-1:0];
        out_rd_     <= mul_rd;
        out_pc_     <= mul_pc;
      end else if (_out_ready) begin
        out_valid_ <= 1'b0;
      end
    end
  end

endmodule

// File: doc/exec_stage.md
Name: exec_stage

Overview:
- Execute stage directly downstream of the decoder and register read in the core.
- Accepts one decoded op per handshake and computes ALU, branch/jump and RV32M multiply results.
- Passes each result with its destination register to writeback through a single-entry output register.
- Resolves control flow and issues a one-cycle redirect to the fetcher.

Parameters:
- WORDSZ, 32, datapath width; only 32 is supported.
- MUL_CYCLES, 32, number of iterations of the iterative multiplier; must equal WORDSZ.

Ports:
- _clk  in  1  clock, all state updates on posedge.
- _reset  in  1  asynchronous, active-low reset.
- _in_valid  in  1  decoded op is present on the input bus.
- in_ready_  out  1  stage can accept an op this cycle.
- _op  in  5  operation code from the shared exec op list.
- _src1  in  32  rs1 value.
- _src2  in  32  rs2 value.
- _imm  in  32  sign-extended immediate.
- _use_imm  in  1  ALU operand B is _imm instead of _src2.
- _pc  in  32  PC of the op.
- _rd  in  5  destination register.
- _flush  in  1  synchronous pipeline kill.
- _en_trace  in  1  enables per-op trace print on acceptance.
- _out_ready  in  1  writeback accepts the output entry.
- out_valid_  out  1  output entry valid.
- out_result_  out  32  result value.
- out_rd_  out  5  destination register; 0 for branches.
- out_pc_  out  32  PC of the producing op.
- redirect_valid_  out  1  one-cycle redirect pulse.
- redirect_pc_  out  32  redirect target.

Behaviour:
- Reset (_reset=0, asynchronous): state=IDLE, mul counter=0, and every output register =0. After reset, in_ready_=1.
- States: IDLE and MUL_BUSY.
- in_ready_ = (state==IDLE) && !_flush && (!out_valid_ || _out_ready). It is combinational.
- Accept condition: _in_valid && in_ready_ at a posedge. An accepted op drains the old output entry in the same edge.
- Single-cycle ops: ADD SUB SLL SLT SLTU XOR SRL SRA OR AND LUI AUIPC JAL JALR BEQ BNE BLT BGE BLTU BGEU.
  - Result is registered on the accept edge; out_valid_=1 in the next cycle (latency 1).
  - Operand B = _use_imm ? _imm : _src2. Shifts use B[4:0]. SRA is arithmetic.
  - LUI result = _imm. AUIPC result = _pc+_imm.
  - Arithmetic wraps mod 2^32.
- JAL/JALR: result = _pc+4.
  - redirect_pc_ = _pc+_imm for JAL, (_src1+_imm)&~1 for JALR.
  - redirect_valid_=1 for exactly one cycle after the accept edge.
- Branches: compare _src1 with _src2, signed for BLT/BGE and unsigned for BLTU/BGEU.
  - If taken: redirect pulse with target _pc+_imm.
  - The output entry is still produced with out_rd_=0 and out_result_=0.
- The redirect pulse is independent of _out_ready.
- MUL MULH MULHSU MULHU: the accept edge latches operands and sets state=MUL_BUSY, counter=0.
  - Each subsequent edge performs one shift-add step on magnitudes and increments the counter.
  - On the edge where counter==MUL_CYCLES-1: the 64-bit product is negated if operand signs differ. MULHSU treats src1 as signed and src2 as unsigned.
  - That same edge writes MUL to the low 32 bits and the MULH variants to the high 32 bits, sets out_valid_=1, and returns state to IDLE.
  - Latency is 32 cycles from acceptance. in_ready_=0 throughout.
  - The output register is guaranteed empty at completion, so the multiplier needs no hold state.
- Output hold: while out_valid_ && !_out_ready, all out_* are stable.
- out_valid_ clears on an edge with _out_ready=1 and no new entry.
- Flush (highest priority, synchronous):
  - On the edge, state=IDLE, counter=0, out_valid_=0, redirect_valid_=0.
  - Any multiply in flight is discarded.
  - in_ready_=0 during the flush cycle, so no op is accepted.
- Reset mid-multiply aborts immediately with no output.
- Unknown op codes are treated as ADD.

Decomposition:
- Shared include core/ExecDefs.vh holds:
  - the 5-bit op code localparams (ADD=0 … BGEU=19, MUL=20, MULH=21, MULHSU=22, MULHU=23);
  - the state encodings.
- The decoder uses the same include to drive _op.
- One sub-module: mul_iter. It contains the sign handling, the 64-bit accumulator, the counter and start/done pulses, and it is flushable.

Test Plan:
- Reset pulse mid-stream -> outputs 0 immediately, in_ready_=1 after release.
- ADD src1=7, imm=-3, use_imm=1, rd=5 -> next cycle out_valid_=1, result=4, rd=5.
- SRA src1=0x80000000, src2=4 -> 0xF8000000. SLTU with 1 vs 0xFFFFFFFF -> 1.
- BEQ 3==3, pc=0x100, imm=0x20 -> one-cycle redirect to 0x120, out_rd_=0. BNE 3,3 -> no redirect.
- JALR src1=0x1001, imm=4, pc=0x40 -> redirect 0x1004, result 0x44.
- MULH 0xFFFFFFFF*0xFFFFFFFF -> 0 after 32 cycles. MULHU -> 0xFFFFFFFE. MUL -> 1. in_ready_ low throughout.
- Flush at cycle 10 of MUL -> no output, in_ready_=1 next cycle.
- Hold _out_ready=0 with a valid ADD result -> in_ready_=0, outputs stable.
- Raise _out_ready with a new op pending -> back-to-back acceptance, no bubble.
